uart: RTL and testbench

// - Full-duplex 8N1 UART: 8 data bits, no parity, 1 stop bit, LSB first, line idles high.
// - A rising edge on UART_TX_TE pushes UART_TX_DR into an 8-deep TX FIFO.
// - The transmitter drains the FIFO back-to-back onto UART_TX.
// - The receiver deserialises UART_RX into UART_RX_DR.
// - Sits between a CPU-style register interface and the board pins. Loopback (TX tied to RX) is a supported use.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART.
package uart_pkg;

   localparam int unsigned BR_MIN    = 4;
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned CNT_W     = 25;

   // Status register bit positions
   localparam int unsigned SR_TXBUSY = 0;
   localparam int unsigned SR_TXE    = 1;
   localparam int unsigned SR_TXF    = 2;
   localparam int unsigned SR_RXDONE = 3;
   localparam int unsigned SR_FE     = 4;
   localparam int unsigned SR_OVR    = 5;
   localparam int unsigned SR_RXBUSY = 6;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   // Bit periods below BR_MIN are raised to BR_MIN.
   function automatic logic [CNT_W-1:0] clamp_br(input logic [CNT_W-1:0] br);
      return (br < CNT_W'(BR_MIN)) ? CNT_W'(BR_MIN) : br;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; push while full and pop while empty are ignored.
module uart_sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [Width-1:0]         din,
   output logic [Width-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);
   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(Depth));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer/count registers with synchronous reset (flushes contents)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART with an 8-deep TX FIFO and a status register.
module uart
   import uart_pkg::*;
#(
   parameter int unsigned TX_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [24:0] UART_BR,
   output logic [7:0]  UART_SR,
   input  logic        UART_RX,
   output logic [7:0]  UART_RX_DR,
   input  logic        UART_TX_TE,
   input  logic [7:0]  UART_TX_DR,
   output logic        UART_TX
);
   localparam int unsigned FCW = $clog2(TX_FIFO_DEPTH) + 1;

   logic             te_q, te_rise, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_dout;
   logic [FCW-1:0]   fifo_count;
   logic             ovr_q, ovr_d;

   tx_state_e        tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, tx_br_q, tx_br_d;
   logic [7:0]       tx_shreg_q, tx_shreg_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic             tx_line_q, tx_line_d;

   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, rx_br_q, rx_br_d;
   logic [7:0]       rx_shreg_q, rx_shreg_d, rx_dr_q, rx_dr_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic             rx_s1_q, rx_s2_q, rx_s3_q;
   logic             rxdone_q, rxdone_d, fe_q, fe_d;

   assign te_rise   = UART_TX_TE && !te_q;
   assign fifo_push = te_rise && !fifo_full;
   assign ovr_d     = ovr_q | (te_rise & fifo_full);

   uart_sync_fifo #(
      .Width (8),
      .Depth (TX_FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (UART_TX_DR),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // TX FSM: line value is registered, so it lags the state by one clock
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_br_d    = tx_br_q;
      tx_shreg_d = tx_shreg_q;
      tx_bit_d   = tx_bit_q;
      tx_line_d  = 1'b1;
      fifo_pop   = 1'b0;
      unique case (tx_state_q)
         TxIdle: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_shreg_d = fifo_dout;
               tx_br_d    = clamp_br(UART_BR);
               tx_cnt_d   = clamp_br(UART_BR) - 1'b1;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            tx_line_d = 1'b0;
            if (tx_cnt_q == '0) begin
               tx_cnt_d   = tx_br_q - 1'b1;
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end else begin
               tx_cnt_d = tx_cnt_q - 1'b1;
            end
         end
         TxData: begin
            tx_line_d = tx_shreg_q[0];
            if (tx_cnt_q == '0) begin
               tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
               tx_cnt_d   = tx_br_q - 1'b1;
               if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                  tx_state_d = TxStop;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 1'b1;
            end
         end
         TxStop: begin
            if (tx_cnt_q == '0) begin
               // Chain straight into the next frame when data is waiting
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  tx_shreg_d = fifo_dout;
                  tx_br_d    = clamp_br(UART_BR);
                  tx_cnt_d   = clamp_br(UART_BR) - 1'b1;
                  tx_state_d = TxStart;
               end else begin
                  tx_state_d = TxIdle;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 1'b1;
            end
         end
      endcase
   end

   // RX FSM: samples the synchronised line at bit centres
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_br_d    = rx_br_q;
      rx_shreg_d = rx_shreg_q;
      rx_bit_d   = rx_bit_q;
      rx_dr_d    = rx_dr_q;
      rxdone_d   = 1'b0;
      fe_d       = fe_q;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_s3_q && !rx_s2_q) begin
               rx_br_d    = clamp_br(UART_BR);
               rx_cnt_d   = (clamp_br(UART_BR) >> 1) - 1'b1;
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (rx_cnt_q == '0) begin
               // A high line at mid start bit is a glitch
               if (rx_s2_q) begin
                  rx_state_d = RxIdle;
               end else begin
                  rx_cnt_d   = rx_br_q - 1'b1;
                  rx_bit_d   = '0;
                  rx_state_d = RxData;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         RxData: begin
            if (rx_cnt_q == '0) begin
               rx_shreg_d = {rx_s2_q, rx_shreg_q[7:1]};
               rx_cnt_d   = rx_br_q - 1'b1;
               if (rx_bit_q == 3'(DATA_BITS - 1)) begin
                  rx_state_d = RxStop;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         RxStop: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = RxIdle;
               if (rx_s2_q) begin
                  rx_dr_d  = rx_shreg_q;
                  rxdone_d = 1'b1;
                  fe_d     = 1'b0;
               end else begin
                  fe_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
      endcase
   end

   // TX state, TE edge detector and overrun flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_br_q    <= CNT_W'(BR_MIN);
         tx_shreg_q <= '0;
         tx_bit_q   <= '0;
         tx_line_q  <= 1'b1;
         te_q       <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_br_q    <= tx_br_d;
         tx_shreg_q <= tx_shreg_d;
         tx_bit_q   <= tx_bit_d;
         tx_line_q  <= tx_line_d;
         te_q       <= UART_TX_TE;
         ovr_q      <= ovr_d;
      end
   end

   // RX synchroniser, RX state and receive status
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_br_q    <= CNT_W'(BR_MIN);
         rx_shreg_q <= '0;
         rx_bit_q   <= '0;
         rx_dr_q    <= '0;
         rxdone_q   <= 1'b0;
         fe_q       <= 1'b0;
      end else begin
         rx_s1_q    <= UART_RX;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_br_q    <= rx_br_d;
         rx_shreg_q <= rx_shreg_d;
         rx_bit_q   <= rx_bit_d;
         rx_dr_q    <= rx_dr_d;
         rxdone_q   <= rxdone_d;
         fe_q       <= fe_d;
      end
   end

   // Status register assembly
   always_comb begin
      UART_SR            = '0;
      UART_SR[SR_TXBUSY] = (tx_state_q != TxIdle);
      UART_SR[SR_TXE]    = (fifo_count == '0);
      UART_SR[SR_TXF]    = fifo_full;
      UART_SR[SR_RXDONE] = rxdone_q;
      UART_SR[SR_FE]     = fe_q;
      UART_SR[SR_OVR]    = ovr_q;
      UART_SR[SR_RXBUSY] = (rx_state_q != RxIdle);
   end

   assign UART_TX    = tx_line_q;
   assign UART_RX_DR = rx_dr_q;

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: TX frames and RX bytes checked against queues.
module tb_uart;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [24:0] UART_BR = 25'd19;
   logic [7:0]  UART_SR;
   logic [7:0]  UART_RX_DR;
   logic        UART_TX_TE = 1'b0;
   logic [7:0]  UART_TX_DR = 8'h00;
   logic        UART_TX;
   logic        loopback = 1'b1;
   logic        rx_drv = 1'b1;
   logic        rx_line;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          mon_br = 19;
   logic        mon_en = 1'b1;
   int          rxdone_cnt = 0;
   logic [7:0]  last_rx = 8'h00;
   logic [7:0]  tx_exp[$];
   logic [7:0]  rx_exp[$];
   int          start_times[$];
   logic [7:0]  rx_mon_exp;

   assign rx_line = loopback ? UART_TX : rx_drv;

   uart #(
      .TX_FIFO_DEPTH (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .UART_BR    (UART_BR),
      .UART_SR    (UART_SR),
      .UART_RX    (rx_line),
      .UART_RX_DR (UART_RX_DR),
      .UART_TX_TE (UART_TX_TE),
      .UART_TX_DR (UART_TX_DR),
      .UART_TX    (UART_TX)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      UART_TX_DR = b;
      UART_TX_TE = 1'b1;
      repeat (hold) @(negedge clk);
      UART_TX_TE = 1'b0;
   endtask

   // Queue a byte on both scoreboards (loopback delivers it to RX too)
   task automatic expect_both(input logic [7:0] b);
      tx_exp.push_back(b);
      rx_exp.push_back(b);
      last_rx = b;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int br);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (br) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (br) @(negedge clk);
      end
      rx_drv = stop;
      repeat (br) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   task automatic wait_drain(input string tag, input int max_cyc);
      int n = 0;
      while ((tx_exp.size() != 0 || rx_exp.size() != 0 || UART_SR[0] || UART_SR[6])
             && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(n < max_cyc), 1);
   endtask

   // Reference receiver on UART_TX
   initial begin
      logic       prev;
      logic [7:0] b;
      int         br;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && prev && !UART_TX) begin
            start_times.push_back(cyc);
            br = mon_br;
            repeat (br / 2) @(negedge clk);
            check_eq("tx_start_bit", 32'(UART_TX), 0);
            for (int i = 0; i < 8; i++) begin
               repeat (br) @(negedge clk);
               b[i] = UART_TX;
            end
            repeat (br) @(negedge clk);
            check_eq("tx_stop_bit", 32'(UART_TX), 1);
            if (tx_exp.size() == 0) begin
               check_eq("tx_unexpected_frame", 32'(tx_exp.size()), 1);
            end else begin
               check_eq("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
            end
         end
         prev = UART_TX;
      end
   end

   // RX scoreboard: each RXDONE pulse consumes one expected byte
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && UART_SR[3]) begin
            rxdone_cnt++;
            if (rx_exp.size() == 0) begin
               check_eq("rx_unexpected_done", 32'(rx_exp.size()), 1);
            end else begin
               rx_mon_exp = rx_exp.pop_front();
               check_eq("rx_byte", 32'(UART_RX_DR), 32'(rx_mon_exp));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n, done_before;
      logic [7:0] dr_before;

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("reset_sr", 32'(UART_SR), 32'h02);
      check_eq("reset_tx", 32'(UART_TX), 1);
      check_eq("reset_rx_dr", 32'(UART_RX_DR), 0);

      // Loopback 0x55 at BR=19, TE held high: exactly one push
      UART_BR = 25'd19;
      mon_br  = 19;
      expect_both(8'h55);
      push_byte(8'h55, 5);
      n = 5;
      while (rx_exp.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("loop_rx_within_200", 32'(n < 200), 1);
      check_eq("loop_rx_dr", 32'(UART_RX_DR), 32'h55);
      wait_drain("loop_drain", 400);

      // Three back-to-back frames at BR=8
      UART_BR = 25'd8;
      mon_br  = 8;
      start_times.delete();
      expect_both(8'hA5);
      expect_both(8'h0F);
      expect_both(8'hFF);
      push_byte(8'hA5, 1);
      push_byte(8'h0F, 1);
      push_byte(8'hFF, 1);
      check_eq("b2b_txe_holding", 32'(UART_SR[1]), 0);
      n = 0;
      while (start_times.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("b2b_txe_before_third_pop", 32'(UART_SR[1]), 0);
      while (start_times.size() < 3 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_eq("b2b_txe_after_third_pop", 32'(UART_SR[1]), 1);
      wait_drain("b2b_drain", 400);
      check_eq("b2b_frames", 32'(start_times.size()), 3);
      if (start_times.size() == 3) begin
         check_eq("b2b_gap_1", 32'(start_times[1] - start_times[0]), 80);
         check_eq("b2b_gap_2", 32'(start_times[2] - start_times[1]), 80);
      end

      // Overflow: first byte goes to the shifter, 8 fill the FIFO, the 10th is dropped
      for (int i = 0; i < 9; i++) begin
         expect_both(8'(8'h10 + i));
      end
      for (int i = 0; i < 10; i++) begin
         push_byte(8'(8'h10 + i), 1);
      end
      @(negedge clk);
      check_eq("ovr_txf", 32'(UART_SR[2]), 1);
      check_eq("ovr_flag", 32'(UART_SR[5]), 1);
      wait_drain("ovr_drain", 1000);
      check_eq("ovr_sticky", 32'(UART_SR[5]), 1);

      // Framing error at BR=16, then a good frame clears FE
      loopback = 1'b0;
      UART_BR  = 25'd16;
      repeat (5) @(negedge clk);
      done_before = rxdone_cnt;
      dr_before   = last_rx;
      send_rx(8'h3C, 1'b0, 16);
      repeat (20) @(negedge clk);
      check_eq("fe_set", 32'(UART_SR[4]), 1);
      check_eq("fe_rx_dr_kept", 32'(UART_RX_DR), 32'(dr_before));
      check_eq("fe_no_rxdone", 32'(rxdone_cnt), 32'(done_before));
      rx_exp.push_back(8'hC3);
      last_rx = 8'hC3;
      send_rx(8'hC3, 1'b1, 16);
      repeat (20) @(negedge clk);
      check_eq("fe_cleared", 32'(UART_SR[4]), 0);
      check_eq("good_rx_dr", 32'(UART_RX_DR), 32'hC3);
      check_eq("good_rxdone", 32'(rxdone_cnt), 32'(done_before + 1));

      // 3-clock glitch is rejected
      done_before = rxdone_cnt;
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("glitch_rxbusy", 32'(UART_SR[6]), 1);
      repeat (20) @(negedge clk);
      check_eq("glitch_rx_idle", 32'(UART_SR[6]), 0);
      check_eq("glitch_rx_dr", 32'(UART_RX_DR), 32'(last_rx));
      check_eq("glitch_fe", 32'(UART_SR[4]), 0);
      check_eq("glitch_no_rxdone", 32'(rxdone_cnt), 32'(done_before));

      // BR=2 behaves as BR=4: 40-clock frames
      loopback = 1'b1;
      repeat (5) @(negedge clk);
      UART_BR = 25'd2;
      mon_br  = 4;
      start_times.delete();
      expect_both(8'h96);
      expect_both(8'h3B);
      push_byte(8'h96, 1);
      push_byte(8'h3B, 1);
      wait_drain("br_min_drain", 300);
      check_eq("br_min_frames", 32'(start_times.size()), 2);
      if (start_times.size() == 2) begin
         check_eq("br_min_frame_len", 32'(start_times[1] - start_times[0]), 40);
      end

      // Reset mid-frame aborts both FSMs and flushes the FIFO
      mon_en  = 1'b0;
      UART_BR = 25'd20;
      push_byte(8'h81, 1);
      push_byte(8'h7E, 1);
      push_byte(8'h42, 1);
      repeat (60) @(negedge clk);
      check_eq("pre_reset_busy", 32'({UART_SR[6], UART_SR[0]}), 32'h3);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rst_tx_high", 32'(UART_TX), 1);
      check_eq("rst_sr", 32'(UART_SR), 32'h02);
      check_eq("rst_rx_dr", 32'(UART_RX_DR), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      repeat (500) @(negedge clk);
      check_eq("post_reset_sr", 32'(UART_SR), 32'h02);
      check_eq("post_reset_tx_left", 32'(tx_exp.size()), 0);
      check_eq("post_reset_rx_left", 32'(rx_exp.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
